// File: rtl/voice_sine_scheduler.sv
// voice_sine_scheduler: time-multiplexes NUM_VOICES phase accumulators onto one sine LUT and mixes the results
// Ports: clk_in/rst_in (async active-low) clock and reset; sample_in frame strobe;
//        cfg_valid_in/cfg_voice_in/cfg_incr_in/cfg_en_in/cfg_ready_out voice config write;
//        lut_phase_out/lut_amp_in shared LUT (1-cycle read latency);
//        mix_out/mix_valid_out mixed sample; busy_out frame in progress; overrun_out sticky dropped frame.
module voice_sine_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sample_in,
  input  logic                          cfg_valid_in,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_in,
  input  logic [PHASE_W-1:0]            cfg_incr_in,
  input  logic                          cfg_en_in,
  output logic                          cfg_ready_out,
  output logic [5:0]                    lut_phase_out,
  input  logic [7:0]                    lut_amp_in,
  output logic signed [9:0]             mix_out,
  output logic                          mix_valid_out,
  output logic                          busy_out,
  output logic                          overrun_out
);
  localparam int VW = $clog2(NUM_VOICES);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t                  r_state, w_next;
  logic [VW-1:0]           r_idx;
  logic [PHASE_W-1:0]      r_acc  [NUM_VOICES];
  logic [PHASE_W-1:0]      r_incr [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_en;
  logic                    r_amp_vld, r_amp_en;
  logic signed [9:0]       r_sum;
  logic signed [7:0]       w_amp_s, w_shift;
  logic signed [9:0]       w_contrib;
  logic                    w_cfg_fire;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE  ? (sample_in ? ISSUE : IDLE) :
             r_state == ISSUE ? (r_idx == VW'(NUM_VOICES - 1) ? DRAIN : ISSUE) :
             r_state == DRAIN ? DONE : IDLE;
  always_comb begin
    busy_out      = r_state != IDLE;
    mix_valid_out = r_state == DONE;
    cfg_ready_out = r_state == IDLE && rst_in;
    lut_phase_out = r_state == ISSUE ? r_acc[r_idx][PHASE_W-1 -: 6] : 6'd0;
  end
  // LUT data arrives one cycle after the phase, so the contribution is tagged with the previous slot's enable
  assign w_amp_s    = {~lut_amp_in[7], lut_amp_in[6:0]};
  assign w_shift    = w_amp_s >>> 2;
  assign w_contrib  = (r_amp_vld && r_amp_en) ? {{2{w_shift[7]}}, w_shift} : 10'sd0;
  assign w_cfg_fire = cfg_valid_in && cfg_ready_out;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      r_idx       <= '0;
      r_amp_vld   <= 1'b0;
      r_amp_en    <= 1'b0;
      r_sum       <= '0;
      mix_out     <= '0;
      overrun_out <= 1'b0;
      r_en        <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_acc[v]  <= '0;
        r_incr[v] <= '0;
      end
    end else begin
      r_idx     <= r_state == ISSUE ? r_idx + VW'(1) : '0;
      r_amp_vld <= r_state == ISSUE;
      r_amp_en  <= r_en[r_idx];
      r_sum     <= r_state == IDLE ? 10'sd0 : r_sum + w_contrib;
      if (r_state == DRAIN) mix_out <= r_sum + w_contrib;
      if (sample_in && r_state != IDLE) overrun_out <= 1'b1;
      for (int v = 0; v < NUM_VOICES; v++)
        if (w_cfg_fire && cfg_voice_in == VW'(v)) begin
          r_incr[v] <= cfg_incr_in;
          r_en[v]   <= cfg_en_in;
          if (!cfg_en_in) r_acc[v] <= '0;
        end else if (r_state == ISSUE && r_idx == VW'(v) && r_en[v])
          r_acc[v] <= r_acc[v] + r_incr[v];
    end
endmodule

// File: tb/tb_voice_sine_scheduler.sv
// tb_voice_sine_scheduler: directed scoreboard bench for voice_sine_scheduler
module tb_voice_sine_scheduler;
  localparam int N = 4;
  logic              clk_in = 0, rst_in = 0, sample_in = 0, cfg_valid_in = 0, cfg_en_in = 0;
  logic [1:0]        cfg_voice_in = '0;
  logic [31:0]       cfg_incr_in = '0;
  logic              cfg_ready_out, mix_valid_out, busy_out, overrun_out;
  logic [5:0]        lut_phase_out;
  logic [7:0]        lut_amp_in = '0;
  logic signed [9:0] mix_out;
  int passes = 0, fails = 0;
  bit          lut_mode = 0;
  logic [7:0]  lut_k = '0;
  bit          exp_ovr = 0;
  logic [31:0] m_acc [N], m_incr [N];
  bit          m_en [N];
  logic [5:0]        q_phase [$];
  logic signed [9:0] q_mix [$];
  voice_sine_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .cfg_valid_in(cfg_valid_in),
    .cfg_voice_in(cfg_voice_in), .cfg_incr_in(cfg_incr_in), .cfg_en_in(cfg_en_in),
    .cfg_ready_out(cfg_ready_out), .lut_phase_out(lut_phase_out), .lut_amp_in(lut_amp_in),
    .mix_out(mix_out), .mix_valid_out(mix_valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [7:0] lut_f(input logic [5:0] p);
    return lut_mode ? {p, 2'b01} : lut_k;
  endfunction
  always @(posedge clk_in) lut_amp_in <= lut_f(lut_phase_out);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_acc[v] = '0;
      m_incr[v] = '0;
      m_en[v] = 0;
    end
  endtask
  task automatic model_cfg(input logic [1:0] v, input logic [31:0] incr, input bit en);
    m_incr[v] = incr;
    m_en[v] = en;
    if (!en) m_acc[v] = '0;
  endtask
  task automatic model_frame();
    int sum = 0;
    for (int v = 0; v < N; v++) begin
      logic [5:0] ph;
      ph = m_acc[v][31:26];
      q_phase.push_back(ph);
      if (m_en[v]) begin
        sum += (int'(lut_f(ph)) >> 2) - 32;
        m_acc[v] += m_incr[v];
      end
    end
    q_mix.push_back(10'(sum));
  endtask
  always @(negedge clk_in)
    if (mix_valid_out) begin
      if (q_mix.size() == 0) chk("unexpected_mix_valid", 1, 0);
      else chk("mix_out", 32'(mix_out), 32'(q_mix.pop_front()));
    end
  task automatic cfg(input logic [1:0] v, input logic [31:0] incr, input bit en);
    cfg_valid_in = 1; cfg_voice_in = v; cfg_incr_in = incr; cfg_en_in = en;
    @(negedge clk_in);
    chk("cfg_ready_idle", cfg_ready_out, 1);
    model_cfg(v, incr, en);
    @(posedge clk_in); #1;
    cfg_valid_in = 0;
  endtask
  task automatic frame(input int extra, input bit hold_cfg, input bit co_cfg,
                       input logic [1:0] cv, input logic [31:0] ci, input bit ce);
    if (co_cfg) begin
      cfg_valid_in = 1; cfg_voice_in = cv; cfg_incr_in = ci; cfg_en_in = ce;
      model_cfg(cv, ci, ce);
    end
    model_frame();
    sample_in = 1;
    @(negedge clk_in);
    chk("ready_cycle0", cfg_ready_out, 1);
    chk("lut_phase_idle", lut_phase_out, 0);
    @(posedge clk_in); #1;
    cfg_valid_in = hold_cfg;
    if (hold_cfg) begin
      cfg_voice_in = cv; cfg_incr_in = ci; cfg_en_in = ce;
    end
    for (int c = 1; c <= N + 2; c++) begin
      sample_in = (extra != 0 && c == extra);
      @(negedge clk_in);
      chk("busy_in_frame", busy_out, 1);
      chk("cfg_ready_busy", cfg_ready_out, 0);
      if (c <= N) chk("lut_phase", lut_phase_out, q_phase.pop_front());
      if (c == N + 1) chk("mix_valid_drain", mix_valid_out, 0);
      if (c == N + 2) chk("mix_valid_done", mix_valid_out, 1);
      if (extra != 0 && c == extra) chk("overrun_before", overrun_out, 0);
      if (extra != 0 && c == extra + 1) begin
        exp_ovr = 1;
        chk("overrun_after", overrun_out, 1);
      end
      @(posedge clk_in); #1;
    end
    sample_in = 0;
    @(negedge clk_in);
    chk("busy_idle", busy_out, 0);
    chk("lut_phase_idle", lut_phase_out, 0);
    chk("overrun_state", overrun_out, 32'(exp_ovr));
    if (hold_cfg) begin
      chk("cfg_ready_first_idle", cfg_ready_out, 1);
      model_cfg(cv, ci, ce);
    end
    @(posedge clk_in); #1;
    cfg_valid_in = 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk_in);
    chk("rst_cfg_ready", cfg_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_mix", 32'(mix_out), 0);
    chk("rst_mix_valid", mix_valid_out, 0);
    chk("rst_overrun", overrun_out, 0);
    chk("rst_lut_phase", lut_phase_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1;
    lut_mode = 1;
    cfg(2'd0, 32'h2000_0000, 1);
    repeat (4) frame(0, 0, 0, 2'd0, 0, 0);
    cfg(2'd1, 32'h0400_0000, 1);
    cfg(2'd2, 32'h1234_5678, 1);
    frame(0, 0, 1, 2'd3, 32'h0900_0000, 1);
    frame(0, 0, 0, 2'd0, 0, 0);
    lut_mode = 0;
    lut_k = 8'hFF; frame(0, 0, 0, 2'd0, 0, 0);
    lut_k = 8'h00; frame(0, 0, 0, 2'd0, 0, 0);
    lut_k = 8'h80; frame(0, 0, 0, 2'd0, 0, 0);
    lut_k = 8'h7F; frame(0, 0, 0, 2'd0, 0, 0);
    lut_mode = 1;
    frame(3, 0, 0, 2'd0, 0, 0);
    repeat (3) @(posedge clk_in);
    #1;
    frame(0, 1, 0, 2'd1, 32'h0400_0000, 0);
    frame(0, 0, 0, 2'd0, 0, 0);
    sample_in = 1;
    @(posedge clk_in); #1;
    sample_in = 0;
    @(posedge clk_in); #3;
    rst_in = 0;
    #1;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_mix", 32'(mix_out), 0);
    chk("midrst_mix_valid", mix_valid_out, 0);
    chk("midrst_overrun", overrun_out, 0);
    chk("midrst_cfg_ready", cfg_ready_out, 0);
    chk("midrst_lut_phase", lut_phase_out, 0);
    model_reset();
    exp_ovr = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("midrst_no_pulse", mix_valid_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1;
    lut_mode = 0; lut_k = 8'hFF;
    frame(0, 0, 0, 2'd0, 0, 0);
    lut_mode = 1;
    cfg(2'd2, 32'hFFFF_FFFF, 1);
    repeat (3) frame(0, 0, 0, 2'd0, 0, 0);
    repeat (4) @(posedge clk_in);
    #1;
    chk("mix_queue_drained", q_mix.size(), 0);
    chk("phase_queue_drained", q_phase.size(), 0);
    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
endmodule
